// File: rtl/controller_link_rx.sv
// rtl/controller_link_rx.sv - controller port receiver: sync, deserialise frames, shift feedback back to the uC.
// Optional even-parity bit enabled by defining CONTROLLER_LINK_PARITY_EN.
module controller_link_rx #(
  parameter int PORTS       = 4,
  parameter int IDLE_CYCLES = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic                 ControllerClk,
  input  logic                 ControllerIn,
  output logic                 ControllerOut,
  input  logic [16*PORTS-1:0]  Feedback,
  output logic                 StateValid,
  output logic [3:0]           StatePort,
  output logic [15:0]          StateButtons,
  output logic                 FrameError
);

`ifdef CONTROLLER_LINK_PARITY_EN
  localparam int FRAME_BITS = 21;
`else
  localparam int FRAME_BITS = 20;
`endif
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, din_sync_q, din_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]  rx_shift_q, rx_shift_d;
  logic [IW-1:0]          idle_cnt_q, idle_cnt_d;
  logic                   frame_done_q, frame_done_d;
  logic [15:0]            tx_shift_q, tx_shift_d;
  logic [4:0]             tx_cnt_q, tx_cnt_d;
  logic                   ctrl_out_q, ctrl_out_d;
  logic                   state_valid_q, state_valid_d;
  logic                   frame_error_q, frame_error_d;
  logic [3:0]             state_port_q, state_port_d;
  logic [15:0]            state_buttons_q, state_buttons_d;

  logic        sync_clk, sync_din, rise, fall, port_ok, parity_ok;
  logic [3:0]  rx_port, new_port;
  logic [15:0] rx_buttons, fb_sel;

  assign sync_clk   = clk_sync_q[SYNC_STAGES-1];
  assign sync_din   = din_sync_q[SYNC_STAGES-1];
  assign rise       = sync_clk & ~clk_prev_q;
  assign fall       = ~sync_clk & clk_prev_q;
  assign rx_port    = rx_shift_q[FRAME_BITS-1 -: 4];
  assign rx_buttons = rx_shift_q[FRAME_BITS-5 -: 16];
  assign port_ok    = ({1'b0, rx_port} < 5'(PORTS));
`ifdef CONTROLLER_LINK_PARITY_EN
  assign parity_ok  = ~^rx_shift_q;
`else
  assign parity_ok  = 1'b1;
`endif
  // ID as it stands once bit 3 is being shifted in
  assign new_port   = {rx_shift_q[2:0], sync_din};

  always_comb begin
    fb_sel = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (new_port == 4'(p)) fb_sel = Feedback[16*p +: 16];
    end
  end

  always_comb begin
    clk_sync_d      = {clk_sync_q[SYNC_STAGES-2:0], ControllerClk};
    din_sync_d      = {din_sync_q[SYNC_STAGES-2:0], ControllerIn};
    clk_prev_d      = sync_clk;
    bit_cnt_d       = bit_cnt_q;
    rx_shift_d      = rx_shift_q;
    idle_cnt_d      = idle_cnt_q;
    frame_done_d    = 1'b0;
    tx_shift_d      = tx_shift_q;
    tx_cnt_d        = tx_cnt_q;
    ctrl_out_d      = ctrl_out_q;
    state_valid_d   = 1'b0;
    frame_error_d   = 1'b0;
    state_port_d    = state_port_q;
    state_buttons_d = state_buttons_q;

    if (fall) begin
      if (tx_cnt_q != 5'd0) begin
        ctrl_out_d = tx_shift_q[15];
        tx_shift_d = {tx_shift_q[14:0], 1'b0};
        tx_cnt_d   = tx_cnt_q - 1'b1;
      end else begin
        ctrl_out_d = 1'b0;
      end
    end

    if (rise) begin
      rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], sync_din};
      idle_cnt_d = '0;
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d    = 5'd0;
        frame_done_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
      if (bit_cnt_q == 5'd3) begin
        tx_shift_d = fb_sel;
        tx_cnt_d   = 5'd16;
      end
    end else if (frame_done_q) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IDLE_MAX) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
      // Abandoned partial frame: report once, then wait for a fresh frame
      if (idle_cnt_q == IDLE_MAX - 1'b1 && bit_cnt_q != 5'd0) begin
        frame_error_d = 1'b1;
        bit_cnt_d     = 5'd0;
        tx_cnt_d      = 5'd0;
        ctrl_out_d    = 1'b0;
      end
    end

    if (frame_done_q) begin
      if (port_ok && parity_ok) begin
        state_valid_d   = 1'b1;
        state_port_d    = rx_port;
        state_buttons_d = rx_buttons;
      end else begin
        frame_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      clk_sync_q      <= '0;
      din_sync_q      <= '0;
      clk_prev_q      <= 1'b0;
      bit_cnt_q       <= '0;
      rx_shift_q      <= '0;
      idle_cnt_q      <= '0;
      frame_done_q    <= 1'b0;
      tx_shift_q      <= '0;
      tx_cnt_q        <= '0;
      ctrl_out_q      <= 1'b0;
      state_valid_q   <= 1'b0;
      frame_error_q   <= 1'b0;
      state_port_q    <= '0;
      state_buttons_q <= '0;
    end else begin
      clk_sync_q      <= clk_sync_d;
      din_sync_q      <= din_sync_d;
      clk_prev_q      <= clk_prev_d;
      bit_cnt_q       <= bit_cnt_d;
      rx_shift_q      <= rx_shift_d;
      idle_cnt_q      <= idle_cnt_d;
      frame_done_q    <= frame_done_d;
      tx_shift_q      <= tx_shift_d;
      tx_cnt_q        <= tx_cnt_d;
      ctrl_out_q      <= ctrl_out_d;
      state_valid_q   <= state_valid_d;
      frame_error_q   <= frame_error_d;
      state_port_q    <= state_port_d;
      state_buttons_q <= state_buttons_d;
    end
  end

  assign ControllerOut = ctrl_out_q;
  assign StateValid    = state_valid_q;
  assign FrameError    = frame_error_q;
  assign StatePort     = state_port_q;
  assign StateButtons  = state_buttons_q;

endmodule

// File: tb/tb_controller_link_rx.sv
// tb/tb_controller_link_rx.sv - directed scoreboard bench for controller_link_rx.
module tb_controller_link_rx;

  logic        Clk = 1'b0;
  logic        ResetN, ControllerClk, ControllerIn;
  logic        ControllerOut, StateValid, FrameError;
  logic [3:0]  StatePort;
  logic [15:0] StateButtons;
  logic [15:0] fb_arr [4];
  logic [63:0] Feedback;

  assign Feedback = {fb_arr[3], fb_arr[2], fb_arr[1], fb_arr[0]};

  always #5 Clk = ~Clk;

  controller_link_rx #(.PORTS(4), .IDLE_CYCLES(1024), .SYNC_STAGES(2)) dut (
    .Clk(Clk), .ResetN(ResetN), .ControllerClk(ControllerClk), .ControllerIn(ControllerIn),
    .ControllerOut(ControllerOut), .Feedback(Feedback), .StateValid(StateValid),
    .StatePort(StatePort), .StateButtons(StateButtons), .FrameError(FrameError)
  );

  typedef struct {
    bit          is_err;
    logic [3:0]  port;
    logic [15:0] buttons;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          passed = 0, failed = 0, total = 0;
  int          n_valid = 0, n_err = 0, exp_valid = 0, exp_err = 0;
  logic [3:0]  last_port = '0;
  logic [15:0] last_btn = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every StateValid/FrameError pulse consumes one expectation
  always @(negedge Clk) begin
    if (ResetN === 1'b1 && (StateValid === 1'b1 || FrameError === 1'b1)) begin
      if (StateValid) n_valid++;
      if (FrameError) n_err++;
      check("pulse_exclusive", 32'(StateValid & FrameError), 32'd0);
      if (sb.size() == 0) begin
        check("spurious_pulse", 32'({StateValid, FrameError}), 32'd0);
      end else begin
        cur = sb.pop_front();
        check("pulse_kind", 32'(FrameError), 32'(cur.is_err));
        if (!cur.is_err) begin
          last_port = cur.port;
          last_btn  = cur.buttons;
        end
        check("state_port", 32'(StatePort), 32'(last_port));
        check("state_buttons", 32'(StateButtons), 32'(last_btn));
      end
    end
  end

  task automatic push_exp(input bit is_err, input logic [3:0] port, input logic [15:0] buttons);
    exp_t e;
    e.is_err = is_err; e.port = port; e.buttons = buttons;
    sb.push_back(e);
    if (is_err) exp_err++; else exp_valid++;
  endtask

  task automatic send_bit(input logic b, input logic exp_out, input int idx);
    ControllerIn = b;
    repeat (6) @(negedge Clk);
    check($sformatf("ctrl_out_bit%0d", idx), 32'(ControllerOut), 32'(exp_out));
    ControllerClk = 1'b1;
    repeat (6) @(negedge Clk);
    ControllerClk = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] port, input logic [15:0] buttons,
                            input bit flip, input bit scramble, input int n_bits);
    logic [20:0] bits;
    logic [15:0] exp_fb;
    logic        exp_out;
    int          nb;
`ifdef CONTROLLER_LINK_PARITY_EN
    nb   = 21;
    bits = {port, buttons, (^{port, buttons}) ^ flip};
`else
    nb   = 20;
    bits = {1'b0, port, buttons};
`endif
    exp_fb = (port < 4'd4) ? fb_arr[port[1:0]] : 16'h0000;
    if (n_bits >= nb) push_exp((port >= 4'd4) || flip, port, buttons);
    for (int i = 0; i < n_bits && i < nb; i++) begin
      exp_out = (i >= 4 && i < 20) ? exp_fb[19-i] : 1'b0;
      if (scramble && i == 6 && port < 4'd4) fb_arr[port[1:0]] = ~fb_arr[port[1:0]];
      send_bit(bits[nb-1-i], exp_out, i);
    end
    if (n_bits >= nb) begin
      repeat (6) @(negedge Clk);
      check("ctrl_out_after_frame", 32'(ControllerOut), 32'd0);
    end
  endtask

  initial begin
    int err_before;
    ResetN = 1'b0; ControllerClk = 1'b0; ControllerIn = 1'b0;
    fb_arr[0] = 16'h1357; fb_arr[1] = 16'hC3A5; fb_arr[2] = 16'hFFFF; fb_arr[3] = 16'h8001;
    repeat (5) @(negedge Clk);
    check("rst_ctrl_out", 32'(ControllerOut), 32'd0);
    check("rst_valid", 32'(StateValid), 32'd0);
    check("rst_port", 32'(StatePort), 32'd0);
    check("rst_buttons", 32'(StateButtons), 32'd0);
    check("rst_error", 32'(FrameError), 32'd0);
    ResetN = 1'b1;
    repeat (5) @(negedge Clk);

    send_frame(4'd1, 16'hA5C3, 1'b0, 1'b0, 32);
    check("basic_valid_count", 32'(n_valid), 32'd1);
    check("basic_err_count", 32'(n_err), 32'd0);

    send_frame(4'd7, 16'h1234, 1'b0, 1'b0, 32);
    check("range_err_count", 32'(n_err), 32'd1);
    check("range_valid_count", 32'(n_valid), 32'd1);

    err_before = n_err;
    send_frame(4'd2, 16'h0F0F, 1'b0, 1'b0, 9);
    push_exp(1'b1, 4'd0, 16'h0000);
    repeat (1100) @(negedge Clk);
    check("timeout_err_count", 32'(n_err), 32'(err_before + 1));
    repeat (1100) @(negedge Clk);
    check("timeout_once", 32'(n_err), 32'(err_before + 1));
    send_frame(4'd2, 16'h0001, 1'b0, 1'b0, 32);

    send_frame(4'd3, 16'h5A5A, 1'b0, 1'b1, 32);

`ifdef CONTROLLER_LINK_PARITY_EN
    send_frame(4'd1, 16'h00FF, 1'b0, 1'b0, 32);
    send_frame(4'd0, 16'h7001, 1'b1, 1'b0, 32);
`endif

    fb_arr[2] = 16'hFFFF;
    send_frame(4'd2, 16'h1234, 1'b0, 1'b0, 32);
    send_frame(4'd2, 16'h4321, 1'b0, 1'b0, 10);
    repeat (6) @(negedge Clk);
    check("pre_reset_ctrl_out", 32'(ControllerOut), 32'd1);
    check("pre_reset_port", 32'(StatePort), 32'd2);
    ResetN = 1'b0;
    #1;
    check("midrst_ctrl_out", 32'(ControllerOut), 32'd0);
    check("midrst_port", 32'(StatePort), 32'd0);
    check("midrst_buttons", 32'(StateButtons), 32'd0);
    check("midrst_valid", 32'(StateValid), 32'd0);
    check("midrst_error", 32'(FrameError), 32'd0);
    last_port = '0;
    last_btn  = '0;
    repeat (4) @(negedge Clk);
    ResetN = 1'b1;
    repeat (4) @(negedge Clk);
    send_frame(4'd0, 16'hFFFF, 1'b0, 1'b0, 32);
    check("post_reset_port", 32'(StatePort), 32'd0);
    check("post_reset_buttons", 32'(StateButtons), 32'hFFFF);

    repeat (20) @(negedge Clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("total_valid", 32'(n_valid), 32'(exp_valid));
    check("total_err", 32'(n_err), 32'(exp_err));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
